aes128_round_sequencer: RTL and testbench
=========================================

AES128_ROUND_SEQUENCER -- requirements
Module: aes128_round_sequencer

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of AES rounds; 10 is the only legal value.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, the new block request.
REQ-005 The block SHALL have port in_ready, output, 1, the request accept strobe.
REQ-006 The block SHALL have ports plain_text and key0, input, 128 each, the block and cipher key, sampled on accept.
REQ-007 The block SHALL have port out_valid, output, 1, meaning cipher_text is valid.
REQ-008 The block SHALL have port out_ready, input, 1, the consumer accept strobe.
REQ-009 The block SHALL have port cipher_text, output, 128, the result register.
REQ-010 The block SHALL have port busy, output, 1, high whenever the block is outside IDLE.
REQ-011 The block SHALL have port rd_kind, output, 2, the round type: 0 = first, 1 = mid, 2 = last.
REQ-012 The block SHALL have ports rd_pt, rd_k0 and rd_key_prev, output, 128 each, the state, key0 and previous round key driven to the shared datapath.
REQ-013 The block SHALL have port rd_rcon, output, 8, the round constant for the key generator.
REQ-014 The block SHALL have ports rd_key_new and rd_ct, input, 128 each, the combinational key-generator and round results returned in the same cycle.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, with a 4-bit round counter rnd.
REQ-016 in_ready SHALL equal (state == IDLE); the block accepts a request when in_valid and in_ready are both high on a clock edge.
REQ-017 On accept, the block SHALL register plain_text into st_reg, key0 into k0_reg and key_reg, set rnd to 1 and enter RUN.
REQ-018 In RUN, the datapath outputs SHALL be driven as follows:
- rd_pt = st_reg
- rd_key_prev = key_reg
- rd_k0 = k0_reg
- rd_kind = 0 when rnd = 1, 2 when rnd = 10, 1 otherwise
REQ-019 rd_rcon SHALL follow rnd 1..10 as 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex), and SHALL be 00 outside RUN.
REQ-020 Each RUN cycle, st_reg SHALL load rd_ct, key_reg SHALL load rd_key_new, and rnd SHALL increment.
REQ-021 When rnd = 10, the block SHALL load rd_ct into cipher_text, clear rnd and enter DONE.
REQ-022 Latency SHALL be exactly 10 RUN cycles: if the accept edge is T, out_valid rises after edge T+10.
REQ-023 In DONE, out_valid SHALL be 1 and cipher_text SHALL be held stable until out_valid and out_ready are both high on an edge, after which the block enters IDLE.
REQ-024 out_ready with out_valid low SHALL be ignored.
REQ-025 in_valid outside IDLE SHALL be ignored; no queuing, and plain_text and key0 may change freely after accept.
REQ-026 The earliest back-to-back accept SHALL be on the edge after the out handshake; there is no same-cycle DONE-to-RUN bypass.
REQ-027 Outside RUN, rd_kind SHALL be 0, and rd_pt and rd_key_prev SHALL hold their register values; the datapath results are ignored.
REQ-028 rnd SHALL never exceed 10; an illegal state SHALL recover to IDLE on the next edge.

Reset
REQ-029 While rst is high, the block SHALL asynchronously force: state = IDLE, rnd = 0, st_reg = key_reg = k0_reg = cipher_text = 0, out_valid = 0, busy = 0, in_ready = 1.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse; the first accept SHALL be possible on the first edge after rst deasserts.

Verification
REQ-031 The bench SHALL connect rd_* to the team's key_generator and first/mid/last round modules as the golden datapath.
REQ-032 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> cipher_text 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 edges after accept.
REQ-033 FIPS-197 App. C.1: key 000102...0f, pt 00112233445566778899aabbccddeeff -> cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a; the rd_rcon trace SHALL equal the REQ-019 list.
REQ-034 Backpressure: out_ready held 0 for 20 cycles -> out_valid and cipher_text stay stable, and in_ready stays 0 despite in_valid = 1.
REQ-035 Reset at RUN rnd = 5 -> all outputs at reset values immediately (asynchronous), no out_valid; a following App. B request yields the correct result.
REQ-036 Back-to-back: two requests with in_valid held and out_ready = 1 -> accepts 12 edges apart, and the second result does not corrupt the first.

Source files
------------

// File: rtl/aes128_round_sequencer.sv
// rtl/aes128_round_sequencer.sv - iterative AES-128 round sequencer driving a shared round datapath
module aes128_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plain_text,
    input  logic [127:0] key0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text,
    output logic         busy,
    output logic [1:0]   rd_kind,
    output logic [127:0] rd_pt,
    output logic [127:0] rd_k0,
    output logic [127:0] rd_key_prev,
    output logic [7:0]   rd_rcon,
    input  logic [127:0] rd_key_new,
    input  logic [127:0] rd_ct
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LAST_RND = 4'(NR);

    localparam logic [1:0] KIND_FIRST = 2'd0;
    localparam logic [1:0] KIND_MID   = 2'd1;
    localparam logic [1:0] KIND_LAST  = 2'd2;

    logic [1:0]   state;
    logic [3:0]   rnd;
    logic [127:0] st_reg;
    logic [127:0] k0_reg;
    logic [127:0] key_reg;

    logic         in_run;
    logic         accept;
    logic         last_rnd;
    logic         rnd_bad;

    assign in_run   = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign last_rnd = (rnd == LAST_RND);
    // A RUN cycle with rnd at 0 or past the last round cannot be reached legally.
    assign rnd_bad  = (rnd == 4'd0) || (rnd > LAST_RND);

    // Handshake/status outputs are pure decodes of the state so reset forces them at once.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // The shared datapath always sees the live registers; only kind and rcon depend on RUN.
    always_comb begin
        rd_pt       = st_reg;
        rd_k0       = k0_reg;
        rd_key_prev = key_reg;
        rd_kind     = KIND_FIRST;
        if (in_run) begin
            if (rnd == 4'd1) begin
                rd_kind = KIND_FIRST;
            end else if (last_rnd) begin
                rd_kind = KIND_LAST;
            end else begin
                rd_kind = KIND_MID;
            end
        end
    end

    // Round constant table indexed by the round number; silent outside RUN.
    always_comb begin
        rd_rcon = 8'h00;
        if (in_run) begin
            case (rnd)
                4'd1:    rd_rcon = 8'h01;
                4'd2:    rd_rcon = 8'h02;
                4'd3:    rd_rcon = 8'h04;
                4'd4:    rd_rcon = 8'h08;
                4'd5:    rd_rcon = 8'h10;
                4'd6:    rd_rcon = 8'h20;
                4'd7:    rd_rcon = 8'h40;
                4'd8:    rd_rcon = 8'h80;
                4'd9:    rd_rcon = 8'h1b;
                4'd10:   rd_rcon = 8'h36;
                default: rd_rcon = 8'h00;
            endcase
        end
    end

    // Control FSM and round counter; an unknown state or counter drops back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rnd   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rnd   <= 4'd1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rnd_bad) begin
                        rnd   <= 4'd0;
                        state <= IDLE;
                    end else if (last_rnd) begin
                        rnd   <= 4'd0;
                        state <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    rnd   <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // State/key registers: load the request on accept, then follow the datapath every RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_reg  <= 128'd0;
            k0_reg  <= 128'd0;
            key_reg <= 128'd0;
        end else if (state == IDLE) begin
            if (accept) begin
                st_reg  <= plain_text;
                k0_reg  <= key0;
                key_reg <= key0;
            end
        end else if (in_run && !rnd_bad) begin
            st_reg  <= rd_ct;
            key_reg <= rd_key_new;
        end
    end

    // Result register captures the final round output and holds it through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cipher_text <= 128'd0;
        end else if (in_run && last_rnd) begin
            cipher_text <= rd_ct;
        end
    end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// tb/tb_aes128_round_sequencer.sv - self-checking bench with golden AES round datapath and block-level reference
module tb_aes128_round_sequencer;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plain_text = 128'd0;
    logic [127:0] key0 = 128'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] cipher_text;
    logic         busy;
    logic [1:0]   rd_kind;
    logic [127:0] rd_pt;
    logic [127:0] rd_k0;
    logic [127:0] rd_key_prev;
    logic [7:0]   rd_rcon;
    logic [127:0] rd_key_new;
    logic [127:0] rd_ct;

    int pass_cnt = 0;
    int total_cnt = 0;

    aes128_round_sequencer #(.NR(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .plain_text(plain_text), .key0(key0),
        .out_valid(out_valid), .out_ready(out_ready),
        .cipher_text(cipher_text), .busy(busy),
        .rd_kind(rd_kind), .rd_pt(rd_pt), .rd_k0(rd_k0),
        .rd_key_prev(rd_key_prev), .rd_rcon(rd_rcon),
        .rd_key_new(rd_key_new), .rd_ct(rd_ct)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        logic [7:0] e;
        inv = 8'h01;
        sq  = a;
        e   = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, sq);
            sq = gmul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] v);
        logic [127:0] o;
        o = 128'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = sbox(v[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127-32*c -: 8];
            a1 = v[119-32*c -: 8];
            a2 = v[111-32*c -: 8];
            a3 = v[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Whole-block reference encryption.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        logic [7:0] rc;
        s  = pt ^ key;
        k  = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k  = key_expand(k, rc);
            s  = (r == 10) ? (sub_shift(s) ^ k) : (mix(sub_shift(s)) ^ k);
            rc = xtime(rc);
        end
        return s;
    endfunction

    // Golden combinational datapath: key generator plus first/mid/last round.
    always_comb begin
        rd_key_new = key_expand(rd_key_prev, rd_rcon);
        case (rd_kind)
            2'd0:    rd_ct = mix(sub_shift(rd_pt ^ rd_k0)) ^ rd_key_new;
            2'd2:    rd_ct = sub_shift(rd_pt) ^ rd_key_new;
            default: rd_ct = mix(sub_shift(rd_pt)) ^ rd_key_new;
        endcase
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] k, output int edges);
        logic acc;
        plain_text = pt;
        key0 = k;
        in_valid = 1'b1;
        edges = 0;
        while (1) begin
            acc = in_ready;
            tick();
            edges++;
            if (acc || edges > 50) break;
        end
        in_valid = 1'b0;
        plain_text = rand128();
        key0 = rand128();
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (cipher_text !== 128'd0) $display("FAIL reset_cipher_text: got %h want 0", cipher_text); else pass_cnt++;
        total_cnt++; if ({rd_pt, rd_k0, rd_key_prev} !== 384'd0) $display("FAIL reset_rd_regs: got %h want 0", {rd_pt, rd_k0, rd_key_prev}); else pass_cnt++;
        total_cnt++; if ({rd_kind, rd_rcon} !== 10'd0) $display("FAIL reset_kind_rcon: got %h want 0", {rd_kind, rd_rcon}); else pass_cnt++;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL idle_out_ready_ignored: got ov=%b ir=%b want 0 1", out_valid, in_ready); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_fips_b();
        int w, n;
        send(B_PT, B_KEY, w);
        total_cnt++; if (w != 1) $display("FAIL b_accept_edge: got %0d want 1", w); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL b_busy_after_accept: got busy=%b ir=%b want 1 0", busy, in_ready); else pass_cnt++;
        wait_out(n);
        total_cnt++; if (n != 10) $display("FAIL b_latency: got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (cipher_text !== B_CT) $display("FAIL b_cipher_text: got %h want %h", cipher_text, B_CT); else pass_cnt++;
        total_cnt++; if (aes_ref(B_PT, B_KEY) !== B_CT) $display("FAIL b_reference_model: got %h want %h", aes_ref(B_PT, B_KEY), B_CT); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b_after_handshake: got ov=%b ir=%b want 0 1", out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_fips_c1();
        int w;
        logic [7:0] rc;
        logic [1:0] kind;
        send(C_PT, C_KEY, w);
        rc = 8'h01;
        for (int i = 0; i < 10; i++) begin
            kind = (i == 0) ? 2'd0 : ((i == 9) ? 2'd2 : 2'd1);
            total_cnt++; if (rd_rcon !== rc) $display("FAIL c1_rcon_round%0d: got %h want %h", i + 1, rd_rcon, rc); else pass_cnt++;
            total_cnt++; if (rd_kind !== kind) $display("FAIL c1_kind_round%0d: got %0d want %0d", i + 1, rd_kind, kind); else pass_cnt++;
            rc = xtime(rc);
            tick();
        end
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL c1_out_valid: got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (cipher_text !== C_CT) $display("FAIL c1_cipher_text: got %h want %h", cipher_text, C_CT); else pass_cnt++;
        total_cnt++; if (rd_rcon !== 8'h00 || rd_kind !== 2'd0) $display("FAIL c1_done_rcon_kind: got %h %0d want 00 0", rd_rcon, rd_kind); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int w, n;
        logic [127:0] pt, k, exp_ct;
        pt = rand128();
        k = rand128();
        exp_ct = aes_ref(pt, k);
        send(pt, k, w);
        wait_out(n);
        total_cnt++; if (cipher_text !== exp_ct) $display("FAIL bp_cipher_text: got %h want %h", cipher_text, exp_ct); else pass_cnt++;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            plain_text = rand128();
            key0 = rand128();
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || cipher_text !== exp_ct || in_ready !== 1'b0)
                $display("FAIL bp_hold_cycle%0d: got ov=%b ir=%b ct=%h want 1 0 %h", i, out_valid, in_ready, cipher_text, exp_ct);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bp_release: got ir=%b busy=%b want 1 0", in_ready, busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int w, n;
        logic saw_valid;
        send(rand128(), rand128(), w);
        n = 0;
        while (rd_rcon !== 8'h10 && n < 20) begin
            tick();
            n++;
        end
        total_cnt++; if (rd_rcon !== 8'h10) $display("FAIL rst_reach_round5: got rcon %h want 10", rd_rcon); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_async_flags: got ov=%b busy=%b ir=%b want 0 0 1", out_valid, busy, in_ready); else pass_cnt++;
        total_cnt++; if ({rd_pt, rd_k0, rd_key_prev, cipher_text} !== 512'd0) $display("FAIL rst_async_regs: got nonzero %h want 0", {rd_pt, rd_key_prev}); else pass_cnt++;
        total_cnt++; if ({rd_kind, rd_rcon} !== 10'd0) $display("FAIL rst_async_kind_rcon: got %h want 0", {rd_kind, rd_rcon}); else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        send(B_PT, B_KEY, w);
        total_cnt++; if (w != 1) $display("FAIL rst_first_accept: got %0d edges want 1", w); else pass_cnt++;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        total_cnt++; if (n != 10) $display("FAIL rst_retry_latency: got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (cipher_text !== B_CT) $display("FAIL rst_retry_cipher_text: got %h want %h", cipher_text, B_CT); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt1, k1, pt2, k2;
        logic [127:0] res[$];
        int acc_edges[$];
        logic acc_now;
        int cyc;
        pt1 = rand128(); k1 = rand128();
        pt2 = rand128(); k2 = rand128();
        plain_text = pt1;
        key0 = k1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (res.size() < 2 && cyc < 80) begin
            acc_now = in_valid && in_ready;
            if (out_valid) res.push_back(cipher_text);
            tick();
            cyc++;
            if (acc_now) begin
                acc_edges.push_back(cyc);
                if (acc_edges.size() == 1) begin
                    plain_text = pt2;
                    key0 = k2;
                end else begin
                    in_valid = 1'b0;
                    plain_text = rand128();
                    key0 = rand128();
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total_cnt++; if (acc_edges.size() != 2 || res.size() != 2) $display("FAIL b2b_counts: got acc=%0d res=%0d want 2 2", acc_edges.size(), res.size()); else pass_cnt++;
        if (acc_edges.size() == 2) begin
            total_cnt++; if (acc_edges[1] - acc_edges[0] != 12) $display("FAIL b2b_spacing: got %0d want 12", acc_edges[1] - acc_edges[0]); else pass_cnt++;
        end
        if (res.size() == 2) begin
            total_cnt++; if (res[0] !== aes_ref(pt1, k1)) $display("FAIL b2b_first_result: got %h want %h", res[0], aes_ref(pt1, k1)); else pass_cnt++;
            total_cnt++; if (res[1] !== aes_ref(pt2, k2)) $display("FAIL b2b_second_result: got %h want %h", res[1], aes_ref(pt2, k2)); else pass_cnt++;
        end
        tick();
    endtask

    task automatic test_random_blocks();
        int w, n, stall;
        logic [127:0] pt, k, exp_ct;
        for (int i = 0; i < 4; i++) begin
            pt = rand128();
            k = rand128();
            exp_ct = aes_ref(pt, k);
            send(pt, k, w);
            wait_out(n);
            total_cnt++; if (n != 10) $display("FAIL rand%0d_latency: got %0d want 10", i, n); else pass_cnt++;
            stall = $urandom_range(0, 5);
            for (int s = 0; s < stall; s++) tick();
            total_cnt++; if (out_valid !== 1'b1 || cipher_text !== exp_ct) $display("FAIL rand%0d_result: got ov=%b ct=%h want 1 %h", i, out_valid, cipher_text, exp_ct); else pass_cnt++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random_blocks();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
